channel_scan_sequencer: RTL and testbench

//  Upstream stage of the 3:8 one-hot decoder. Generates the 3-bit channel select code

---
 rtl/channel_scan_sequencer.sv | 148 ++++++++++++++
 tb/tb_channel_scan_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/channel_scan_sequencer.sv
// Channel scan sequencer: steps a 3:8 decoder select code through enabled
// channels with a programmable dwell, in single-pass or continuous mode.
module channel_scan_sequencer #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   mode_single,
    input  logic [DWELL_W-1:0]     dwell,
    input  logic [(2**SEL_W)-1:0]  ch_mask,
    output logic [SEL_W-1:0]       sel,
    output logic                   sel_valid,
    output logic                   busy,
    output logic                   pass_done,
    output logic                   err_no_ch
);

    localparam int N_CH = 2 ** SEL_W;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state, state_n;
    logic [SEL_W-1:0]     sel_n;
    logic                 valid_n, busy_n, pd_n, err_n;
    logic [DWELL_W-1:0]   cnt, cnt_n;
    logic [DWELL_W-1:0]   dwell_q, dwell_n;
    logic [N_CH-1:0]      mask_q, mask_n;
    logic                 single_q, single_n;
    logic [SEL_W:0]       low_in, low_q, nxt_q, above_n;

    // Returns {found, index} of the lowest set bit of m at or above lo.
    function automatic logic [SEL_W:0] find_from(
        input logic [N_CH-1:0] m,
        input int              lo
    );
        logic [SEL_W:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i >= lo && m[i]) begin
                r = {1'b1, SEL_W'(i)};
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            pass_done <= 1'b0;
            err_no_ch <= 1'b0;
            cnt       <= '0;
            dwell_q   <= '0;
            mask_q    <= '0;
            single_q  <= 1'b0;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            sel_valid <= valid_n;
            busy      <= busy_n;
            pass_done <= pd_n;
            err_no_ch <= err_n;
            cnt       <= cnt_n;
            dwell_q   <= dwell_n;
            mask_q    <= mask_n;
            single_q  <= single_n;
        end
    end

    always_comb begin
        state_n  = state;
        sel_n    = sel;
        valid_n  = sel_valid;
        busy_n   = busy;
        err_n    = 1'b0;
        cnt_n    = cnt;
        dwell_n  = dwell_q;
        mask_n   = mask_q;
        single_n = single_q;

        low_in = find_from(ch_mask, 0);
        low_q  = find_from(mask_q, 0);
        nxt_q  = find_from(mask_q, int'(sel) + 1);

        unique case (state)
            IDLE: begin
                valid_n = 1'b0;
                busy_n  = 1'b0;
                if (start && !stop) begin
                    if (ch_mask != '0) begin
                        mask_n   = ch_mask;
                        dwell_n  = (dwell == '0) ? DWELL_W'(1) : dwell;
                        single_n = mode_single;
                        state_n  = RUN;
                        sel_n    = low_in[SEL_W-1:0];
                        cnt_n    = '0;
                        valid_n  = 1'b1;
                        busy_n   = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                    cnt_n   = '0;
                end else if (cnt == dwell_q - DWELL_W'(1)) begin
                    cnt_n = '0;
                    if (nxt_q[SEL_W]) begin
                        sel_n = nxt_q[SEL_W-1:0];
                    end else if (single_q) begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                        busy_n  = 1'b0;
                    end else begin
                        sel_n = low_q[SEL_W-1:0];
                    end
                end else begin
                    cnt_n = cnt + DWELL_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                busy_n  = 1'b0;
            end
        endcase

        // pass_done is registered, so predict whether the next cycle is
        // the final dwell cycle of the highest enabled channel.
        above_n = find_from(mask_n, int'(sel_n) + 1);
        pd_n    = (state_n == RUN)
               && (cnt_n == dwell_n - DWELL_W'(1))
               && !above_n[SEL_W];
    end

endmodule

// File: tb/tb_channel_scan_sequencer.sv
// Directed bench for channel_scan_sequencer; cycle 0 is the cycle in
// which start is sampled, later cycles are observed at the falling edge.
module tb_channel_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, mode_single;
    logic [7:0] dwell;
    logic [7:0] ch_mask;
    logic [2:0] sel;
    logic       sel_valid, busy, pass_done, err_no_ch;

    int checks = 0;
    int errors = 0;

    channel_scan_sequencer #(.SEL_W(3), .DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .mode_single(mode_single), .dwell(dwell), .ch_mask(ch_mask),
        .sel(sel), .sel_valid(sel_valid), .busy(busy),
        .pass_done(pass_done), .err_no_ch(err_no_ch)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int s, input int v,
                           input int b, input int pd, input int er);
        chk({tag, ".sel"}, int'(sel), s);
        chk({tag, ".sel_valid"}, int'(sel_valid), v);
        chk({tag, ".busy"}, int'(busy), b);
        chk({tag, ".pass_done"}, int'(pass_done), pd);
        chk({tag, ".err_no_ch"}, int'(err_no_ch), er);
    endtask

    initial begin
        rst_n = 1'b0; start = 0; stop = 0; mode_single = 0;
        dwell = 0; ch_mask = 0;
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        chk_all("idle_after_reset", 0, 0, 0, 0, 0);

        // full mask, dwell 2, continuous
        ch_mask = 8'hFF; dwell = 8'd2; mode_single = 0; start = 1;
        tick();
        start = 0;
        for (int c = 1; c <= 17; c++) begin
            chk_all($sformatf("ff_c%0d", c), (c <= 16) ? (c - 1) / 2 : 0,
                    1, 1, (c == 16) ? 1 : 0, 0);
            tick();
        end
        stop = 1;
        tick();
        stop = 0;
        chk("ff_stop.valid", int'(sel_valid), 0);
        chk("ff_stop.busy", int'(busy), 0);

        // sparse mask, dwell 1, single pass
        ch_mask = 8'b1010_0100; dwell = 8'd1; mode_single = 1; start = 1;
        tick();
        start = 0;
        chk_all("sp_c1", 2, 1, 1, 0, 0);
        tick();
        chk_all("sp_c2", 5, 1, 1, 0, 0);
        tick();
        chk_all("sp_c3", 7, 1, 1, 1, 0);
        tick();
        chk_all("sp_c4", 7, 0, 0, 0, 0);
        tick();
        chk_all("sp_c5", 7, 0, 0, 0, 0);

        // empty mask
        ch_mask = 8'h00; start = 1;
        tick();
        start = 0;
        chk_all("nomask_c1", 7, 0, 0, 0, 1);
        tick();
        chk_all("nomask_c2", 7, 0, 0, 0, 0);

        // stop in 2nd cycle of a dwell=4 code
        ch_mask = 8'hFF; dwell = 8'd4; mode_single = 0; start = 1;
        tick();
        start = 0;
        chk_all("stop_c1", 0, 1, 1, 0, 0);
        tick();
        chk_all("stop_c2", 0, 1, 1, 0, 0);
        stop = 1;
        tick();
        stop = 0;
        chk_all("stop_c3", 0, 0, 0, 0, 0);

        // start together with stop in IDLE
        ch_mask = 8'h10; start = 1; stop = 1;
        tick();
        start = 0; stop = 0;
        chk_all("startstop_c1", 0, 0, 0, 0, 0);
        tick();
        chk_all("startstop_c2", 0, 0, 0, 0, 0);

        // dwell 0 treated as 1, single channel continuous
        ch_mask = 8'h01; dwell = 8'd0; mode_single = 0; start = 1;
        tick();
        start = 0;
        for (int c = 1; c <= 6; c++) begin
            chk_all($sformatf("d0_c%0d", c), 0, 1, 1, 1, 0);
            if (c == 2) begin
                ch_mask = 8'hF0; dwell = 8'd5; mode_single = 1; start = 1;
            end else begin
                start = 0;
            end
            tick();
        end

        // async reset mid-run
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk_all("post_rst_idle", 0, 0, 0, 0, 0);

        // resume requires a new start
        ch_mask = 8'h08; dwell = 8'd3; mode_single = 1; start = 1;
        tick();
        start = 0;
        chk_all("resume_c1", 3, 1, 1, 0, 0);
        tick();
        tick();
        chk_all("resume_c3", 3, 1, 1, 1, 0);
        tick();
        chk_all("resume_c4", 3, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
